// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int unsigned DEFAULT_XLEN  = 32;
    localparam int unsigned DEFAULT_NREGS = 32;

    function automatic int unsigned rf_aw(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: zeroes one entry per cycle, then raises ready.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DEFAULT_NREGS
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    clr_we,
    output logic [rf_aw(NREGS)-1:0] clr_addr,
    output logic                    ready
);

    localparam int unsigned AW = rf_aw(NREGS);

    rf_state_t         state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        unique case (state_q)
            RF_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = RF_READY;
                    ready_d = 1'b1;
                    idx_d   = '0;
                end
            end
            RF_READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = RF_CLEAR;
                idx_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign clr_we   = (state_q == RF_CLEAR);
    assign clr_addr = idx_q;
    assign ready    = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads and a post-reset clear.
// Define REGFILE_BYPASS_EN for write-first reads of same-cycle writes (read-first otherwise).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = DEFAULT_XLEN,
    parameter int unsigned NREGS  = DEFAULT_NREGS,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD*rf_aw(NREGS)-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]         rd_data,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*rf_aw(NREGS)-1:0] wr_addr,
    input  logic [NUM_WR*XLEN-1:0]         wr_data,
    output logic                           ready
);

    localparam int unsigned AW = rf_aw(NREGS);

    logic                   clr_we;
    logic [AW-1:0]          clr_addr;

    logic [XLEN-1:0]        mem_q [NREGS];
    logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;

    logic                   we_c [NUM_WR];
    logic [AW-1:0]          wa_c [NUM_WR];
    logic [XLEN-1:0]        wd_c [NUM_WR];

    logic [AW-1:0]          ra;
    logic [XLEN-1:0]        rval;

    regfile_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Write-port steering; the clear engine takes over port 0 while clearing.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wa_c[w] = wr_addr[w*AW +: AW];
            wd_c[w] = wr_data[w*XLEN +: XLEN];
            we_c[w] = ready && !reset && wr_en[w] && (wa_c[w] != '0);
        end
        if (clr_we) begin
            we_c[0] = 1'b1;
            wa_c[0] = clr_addr;
            wd_c[0] = '0;
        end
    end

    // Higher-numbered ports are applied last so port 1 wins a same-address conflict.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WR; w++) begin
            if (we_c[w]) begin
                mem_q[wa_c[w]] <= wd_c[w];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        ra        = '0;
        rval      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra   = rd_addr[i*AW +: AW];
            rval = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                    rval = wr_data[w*XLEN +: XLEN];
                end
            end
`endif
            if (ready && (ra != '0)) begin
                rd_data_d[i*XLEN +: XLEN] = rval;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (32x32, two read ports, two write ports).
module tb_regfile_mp;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned AW     = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*XLEN-1:0]  rd_data;
    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*XLEN-1:0]  wr_data;
    logic                    ready;

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     due;
        logic [31:0]     rd0;
        logic [31:0]     rd1;
        logic            rdy;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Reference model: architectural contents plus remaining clear cycles.
    logic [31:0] model [NREGS];
    int          clear_left = NREGS;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    endtask

    // Monitor: compares DUT outputs against the entry due this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("rd_data[0]", rd_data[31:0], e.rd0);
            check("rd_data[1]", rd_data[63:32], e.rd1);
            check("ready", {31'b0, ready}, {31'b0, e.rdy});
        end
    end

    function automatic logic [31:0] predict_read(input logic [4:0] ra, input logic [1:0] we,
                                                 input logic [4:0] wa0, input logic [4:0] wa1,
                                                 input logic [31:0] wd0, input logic [31:0] wd1);
        logic [31:0] v;
        if (ra == 0) return 32'h0;
        v = model[ra];
        if (BYPASS) begin
            if (we[1] && wa1 == ra) v = wd1;
            else if (we[0] && wa0 == ra) v = wd0;
        end
        return v;
    endfunction

    task automatic step(input logic rst, input logic [1:0] we,
                        input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        reset   = rst;
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0};
        e.due = cyc + 1;
        if (rst) begin
            for (int r = 0; r < NREGS; r++) model[r] = 32'h0;
            clear_left = NREGS;
            e.rd0 = 0; e.rd1 = 0; e.rdy = 1'b0;
        end else if (clear_left > 0) begin
            clear_left--;
            e.rd0 = 0; e.rd1 = 0; e.rdy = (clear_left == 0);
        end else begin
            e.rd0 = predict_read(ra0, we, wa0, wa1, wd0, wd1);
            e.rd1 = predict_read(ra1, we, wa0, wa1, wd0, wd1);
            e.rdy = 1'b1;
            if (we[0] && wa0 != 0) model[wa0] = wd0;
            if (we[1] && wa1 != 0) model[wa1] = wd1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                                         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 2'b01, a, 5'd0, d, 32'h0, 5'd0, 5'd0);
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, a0, a1);
    endtask

    initial begin
        reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        @(posedge clk); #1;

        // Reset, full clear, then every entry reads zero.
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        idle(NREGS);
        for (int a = 0; a < NREGS; a += 2) rd2(5'(a), 5'(a + 1));

        // Basic write then dual-port read.
        wr1(5'd5, 32'hDEADBEEF);
        rd2(5'd5, 5'd5);

        // Register 0 is hardwired.
        wr1(5'd0, 32'h12345678);
        rd2(5'd0, 5'd0);

        // Same-cycle read/write of x7.
        wr1(5'd7, 32'h11111111);
        step(1'b0, 2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7);
        rd2(5'd7, 5'd7);

        // Dual-write conflict: port 1 wins, also on the bypass path.
        step(1'b0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h2, 5'd9, 5'd5);
        rd2(5'd9, 5'd9);

        // Reset mid-clear; writes during clear are ignored.
        wr1(5'd3, 32'hCAFE0003);
        rd2(5'd3, 5'd3);
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);
        idle(10);
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);
        step(1'b0, 2'b11, 5'd3, 5'd3, 32'hBAD0BAD0, 32'hBAD1BAD1, 5'd3, 5'd3);
        idle(NREGS - 1);
        rd2(5'd3, 5'd3);

        // Randomised traffic with biased address range to force collisions.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom(), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(NREGS + 2);

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
